// File: rtl/collision_event_scheduler.sv
// Collects monkey/object pixel collisions per frame and delivers them as ordered valid/ready events.
// Build option: define OVERRUN_MERGE_EN to merge undrained events into the next snapshot instead of dropping them.
module collision_event_scheduler #(
  parameter int COOLDOWN_FRAMES = 60,
  parameter int CNT_W           = 6
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       drawing_request_Monkey,
  input  logic       drawing_request_Enemy,
  input  logic       drawing_request_Wall,
  input  logic       drawing_request_Rope,
  input  logic       drawing_request_Fruit,
  input  logic       evt_ready,
  output logic       evt_valid,
  output logic [2:0] evt_code,
  output logic [3:0] frame_events,
  output logic       cooldown_active,
  output logic       overrun_pulse
);

  // state | meaning
  // IDLE  | nothing presented; waits for a nonzero pending set
  // ISSUE | evt_code presented with evt_valid=1 until the pending set drains
  typedef enum logic {IDLE = 1'b0, ISSUE = 1'b1} state_t;

  localparam logic [2:0] CODE_NONE  = 3'd0;
  localparam logic [2:0] CODE_ENEMY = 3'd1;

  state_t           r_state, w_state_nxt;
  logic [3:0]       r_acc, r_pend, r_frame_events;
  logic [3:0]       w_hits, w_pend_after, w_pend_nxt;
  logic [2:0]       r_code, w_code_nxt;
  logic [CNT_W-1:0] r_cd;
  logic             r_overrun;
  logic             w_xfer, w_xfer_enemy;

  function automatic logic [2:0] prio_code(input logic [3:0] p);
    if (p[0])      prio_code = 3'd1;
    else if (p[1]) prio_code = 3'd2;
    else if (p[2]) prio_code = 3'd3;
    else if (p[3]) prio_code = 3'd4;
    else           prio_code = CODE_NONE;
  endfunction

  function automatic logic [3:0] code_mask(input logic [2:0] c);
    case (c)
      3'd1:    code_mask = 4'b0001;
      3'd2:    code_mask = 4'b0010;
      3'd3:    code_mask = 4'b0100;
      3'd4:    code_mask = 4'b1000;
      default: code_mask = 4'b0000;
    endcase
  endfunction

  assign cooldown_active = (r_cd != '0);
  assign evt_valid       = (r_state == ISSUE);
  assign evt_code        = r_code;
  assign frame_events    = r_frame_events;
  assign overrun_pulse   = r_overrun;

  // Bit order {FRUIT, ROPE, WALL, ENEMY}; enemy hits are ignored during invulnerability.
  assign w_hits = {drawing_request_Monkey & drawing_request_Fruit,
                   drawing_request_Monkey & drawing_request_Rope,
                   drawing_request_Monkey & drawing_request_Wall,
                   drawing_request_Monkey & drawing_request_Enemy & ~cooldown_active};

  assign w_xfer       = evt_valid & evt_ready;
  assign w_xfer_enemy = w_xfer & (r_code == CODE_ENEMY);

  always_comb begin
    w_pend_after = r_pend;
    if (w_xfer_enemy)
      w_pend_after = '0;
    else if (w_xfer)
      w_pend_after = r_pend & ~code_mask(r_code);
    w_pend_nxt = w_pend_after;
    if (startOfFrame) begin
`ifdef OVERRUN_MERGE_EN
      w_pend_nxt = w_pend_after | r_acc;
`else
      w_pend_nxt = r_acc;
`endif
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_code_nxt  = r_code;
    case (r_state)
      IDLE: begin
        w_code_nxt = CODE_NONE;
        if ((r_pend != '0) && (w_pend_nxt != '0)) begin
          w_state_nxt = ISSUE;
          w_code_nxt  = prio_code(w_pend_nxt);
        end
      end
      ISSUE: begin
        if (w_xfer) begin
          if (w_pend_nxt != '0) begin
            w_code_nxt = prio_code(w_pend_nxt);
          end else begin
            w_state_nxt = IDLE;
            w_code_nxt  = CODE_NONE;
          end
        end
`ifndef OVERRUN_MERGE_EN
        // A blocked event is discarded by the replacing snapshot; drop valid for a cycle.
        else if (startOfFrame) begin
          w_state_nxt = IDLE;
          w_code_nxt  = CODE_NONE;
        end
`endif
      end
      default: begin
        w_state_nxt = IDLE;
        w_code_nxt  = CODE_NONE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge resetN) begin
    if (resetN) begin
      r_state        <= IDLE;
      r_code         <= CODE_NONE;
      r_acc          <= '0;
      r_pend         <= '0;
      r_frame_events <= '0;
      r_overrun      <= 1'b0;
      r_cd           <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_code    <= w_code_nxt;
      r_pend    <= w_pend_nxt;
      r_overrun <= startOfFrame & (w_pend_after != '0);
      if (startOfFrame) begin
        r_acc          <= w_hits;
        r_frame_events <= r_acc;
      end else begin
        r_acc <= r_acc | w_hits;
      end
      if (w_xfer_enemy)
        r_cd <= CNT_W'(COOLDOWN_FRAMES);
      else if (startOfFrame && cooldown_active)
        r_cd <= r_cd - CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_collision_event_scheduler.sv
// Bench for collision_event_scheduler: per-frame vector table plus hand sequences, events checked via a queue.
module tb_collision_event_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic       sof, dr_monkey, dr_enemy, dr_wall, dr_rope, dr_fruit, evt_ready;
  logic       evt_valid;
  logic [2:0] evt_code;
  logic [3:0] frame_events;
  logic       cooldown_active;
  logic       overrun_pulse;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  typedef struct {
    logic       m;
    logic [3:0] obj;
    logic [3:0] fe;
    logic [8:0] codes;
    logic       cd;
  } vec_t;
  vec_t vecs[8];

  collision_event_scheduler #(.COOLDOWN_FRAMES(3), .CNT_W(6)) dut (
    .clk                   (clk),
    .resetN                (rst),
    .startOfFrame          (sof),
    .drawing_request_Monkey(dr_monkey),
    .drawing_request_Enemy (dr_enemy),
    .drawing_request_Wall  (dr_wall),
    .drawing_request_Rope  (dr_rope),
    .drawing_request_Fruit (dr_fruit),
    .evt_ready             (evt_ready),
    .evt_valid             (evt_valid),
    .evt_code              (evt_code),
    .frame_events          (frame_events),
    .cooldown_active       (cooldown_active),
    .overrun_pulse         (overrun_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input logic s, input logic m, input logic [3:0] obj, input logic rdy);
    sof = s; dr_monkey = m;
    {dr_fruit, dr_rope, dr_wall, dr_enemy} = obj;
    evt_ready = rdy;
    @(posedge clk); #1;
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    sof = 1'b0; dr_monkey = 1'b0; {dr_fruit, dr_rope, dr_wall, dr_enemy} = 4'b0; evt_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int i = 0; i < n; i++) tick(1'b0, 1'b0, 4'b0, rdy);
  endtask

  initial begin
    vec_t v;
    logic [8:0] cs;
    logic [2:0] c;

    vecs[0] = '{1'b1, 4'b1010, 4'b1010, {3'd0, 3'd4, 3'd2}, 1'b0};
    vecs[1] = '{1'b1, 4'b0101, 4'b0101, {3'd0, 3'd0, 3'd1}, 1'b1};
    vecs[2] = '{1'b1, 4'b1110, 4'b1110, {3'd4, 3'd3, 3'd2}, 1'b0};
    vecs[3] = '{1'b0, 4'b1111, 4'b0000, {3'd0, 3'd0, 3'd0}, 1'b0};
    vecs[4] = '{1'b1, 4'b1000, 4'b1000, {3'd0, 3'd0, 3'd4}, 1'b0};
    vecs[5] = '{1'b1, 4'b0001, 4'b0001, {3'd0, 3'd0, 3'd1}, 1'b1};
    vecs[6] = '{1'b1, 4'b1111, 4'b1111, {3'd0, 3'd0, 3'd1}, 1'b1};
    vecs[7] = '{1'b1, 4'b0100, 4'b0100, {3'd0, 3'd0, 3'd3}, 1'b0};

    // Consumer-side monitor: every transfer must match the head of the expected queue.
    fork
      forever begin
        @(negedge clk);
        if (!rst && evt_valid && evt_ready) begin
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_event: got code %0d expected no event at %0t", evt_code, $time);
          end else begin
            chk("event_code", {29'd0, evt_code}, {29'd0, exp_q.pop_front()});
          end
        end
      end
    join_none

    rst = 1'b1;
    sof = 1'b0; dr_monkey = 1'b0; {dr_fruit, dr_rope, dr_wall, dr_enemy} = 4'b0; evt_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_evt_valid", evt_valid, 0);
    chk("reset_evt_code", evt_code, 0);
    chk("reset_frame_events", frame_events, 0);
    chk("reset_cooldown", cooldown_active, 0);
    chk("reset_overrun", overrun_pulse, 0);
    rst = 1'b0;

    for (int n = 0; n < 8; n++) begin
      v = vecs[n];
      apply_reset();
      tick(1'b1, 1'b0, 4'b0, 1'b1);
      idle(2, 1'b1);
      tick(1'b0, v.m, v.obj, 1'b1);
      idle(1, 1'b1);
      tick(1'b1, 1'b0, 4'b0, 1'b1);
      cs = v.codes;
      for (int k = 0; k < 3; k++) begin
        c = cs[k*3 +: 3];
        if (c != 3'd0) exp_q.push_back(c);
      end
      chk("vec_frame_events", frame_events, v.fe);
      idle(6, 1'b1);
      chk("vec_all_delivered", exp_q.size(), 0);
      chk("vec_valid_low", evt_valid, 0);
      chk("vec_cooldown", cooldown_active, v.cd);
    end

    // Two-clock latency and a WALL held under backpressure.
    apply_reset();
    tick(1'b1, 1'b0, 4'b0, 1'b0);
    idle(1, 1'b0);
    tick(1'b0, 1'b1, 4'b0010, 1'b0);
    idle(1, 1'b0);
    tick(1'b1, 1'b0, 4'b0, 1'b0);
    exp_q.push_back(3'd2);
    chk("latency_sof_plus1", evt_valid, 0);
    idle(1, 1'b0);
    chk("latency_sof_plus2", {evt_valid, evt_code}, {1'b1, 3'd2});
    for (int i = 0; i < 10; i++) begin
      idle(1, 1'b0);
      chk("hold_under_backpressure", {evt_valid, evt_code}, {1'b1, 3'd2});
    end
    idle(1, 1'b1);
    chk("after_single_wall", evt_valid, 0);
    idle(3, 1'b1);
    chk("wall_delivered_once", exp_q.size(), 0);

    // Enemy cooldown window over three frames.
    apply_reset();
    tick(1'b1, 1'b0, 4'b0, 1'b1);
    idle(2, 1'b1);
    tick(1'b0, 1'b1, 4'b0001, 1'b1);
    idle(1, 1'b1);
    tick(1'b1, 1'b0, 4'b0, 1'b1);
    exp_q.push_back(3'd1);
    idle(4, 1'b1);
    chk("cooldown_after_enemy", cooldown_active, 1);
    for (int k = 1; k <= 3; k++) begin
      idle(3, 1'b1);
      tick(1'b0, 1'b1, 4'b0001, 1'b1);
      idle(2, 1'b1);
      tick(1'b1, 1'b0, 4'b0, 1'b1);
      chk("cooldown_frame", cooldown_active, (k < 3) ? 1 : 0);
      idle(2, 1'b1);
      chk("no_enemy_in_cooldown", evt_valid, 0);
    end
    idle(1, 1'b1);
    tick(1'b0, 1'b1, 4'b0001, 1'b1);
    idle(1, 1'b1);
    tick(1'b1, 1'b0, 4'b0, 1'b1);
    exp_q.push_back(3'd1);
    chk("enemy_after_cd_sof_plus1", evt_valid, 0);
    idle(1, 1'b1);
    chk("enemy_after_cd_sof_plus2", {evt_valid, evt_code}, {1'b1, 3'd1});
    idle(3, 1'b1);
    chk("enemy_after_cd_delivered", exp_q.size(), 0);

    // Overrun: ROPE left undrained when a FRUIT frame closes.
    apply_reset();
    tick(1'b1, 1'b0, 4'b0, 1'b0);
    idle(1, 1'b0);
    tick(1'b0, 1'b1, 4'b0100, 1'b0);
    idle(1, 1'b0);
    tick(1'b1, 1'b0, 4'b0, 1'b0);
`ifdef OVERRUN_MERGE_EN
    exp_q.push_back(3'd3);
`endif
    chk("no_overrun_first_sof", overrun_pulse, 0);
    idle(1, 1'b0);
    chk("rope_presented", {evt_valid, evt_code}, {1'b1, 3'd3});
    idle(1, 1'b0);
    tick(1'b0, 1'b1, 4'b1000, 1'b0);
    idle(1, 1'b0);
    tick(1'b1, 1'b0, 4'b0, 1'b0);
    exp_q.push_back(3'd4);
    chk("overrun_pulse_high", overrun_pulse, 1);
    chk("overrun_frame_events", frame_events, 4'b1000);
`ifdef OVERRUN_MERGE_EN
    chk("overrun_rope_kept", {evt_valid, evt_code}, {1'b1, 3'd3});
`else
    chk("overrun_valid_gap", evt_valid, 0);
`endif
    idle(1, 1'b1);
    chk("overrun_fruit_presented", {evt_valid, evt_code}, {1'b1, 3'd4});
    chk("overrun_pulse_one_cycle", overrun_pulse, 0);
    idle(1, 1'b1);
    chk("overrun_drained", evt_valid, 0);
    chk("overrun_all_delivered", exp_q.size(), 0);

    // Asynchronous reset in the middle of a presented event.
    apply_reset();
    tick(1'b1, 1'b0, 4'b0, 1'b0);
    idle(1, 1'b0);
    tick(1'b0, 1'b1, 4'b1111, 1'b0);
    idle(1, 1'b0);
    tick(1'b1, 1'b0, 4'b0, 1'b0);
    idle(1, 1'b0);
    chk("pre_reset_valid", evt_valid, 1);
    rst = 1'b1;
    #2;
    chk("async_reset_valid", evt_valid, 0);
    chk("async_reset_code", evt_code, 0);
    chk("async_reset_frame_events", frame_events, 0);
    chk("async_reset_cooldown", cooldown_active, 0);
    exp_q.delete();
    rst = 1'b0;
    idle(5, 1'b1);
    chk("no_event_after_reset", evt_valid, 0);
    idle(1, 1'b1);
    tick(1'b0, 1'b1, 4'b1000, 1'b1);
    idle(1, 1'b1);
    tick(1'b1, 1'b0, 4'b0, 1'b1);
    exp_q.push_back(3'd4);
    idle(5, 1'b1);
    chk("post_reset_event_delivered", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
